sweep_controller: RTL and testbench

Sequencer for the team's 8-bit up/down counter. The block owns one counter instance and drives its `enable`/`direction` pins to run programmable triangular sweeps between a low and a high bound. Each sweep has an optional dwell at each bound and a programmable repeat count. It sits between a host start/abort interface and the counter, and exposes the live count for downstream stimulus and PWM logic.

---
 rtl/sweep_pkg.sv | 16 +
 rtl/updown_counter8.sv | 19 +
 rtl/sweep_controller.sv | 148 ++++++++++++++
 tb/tb_sweep_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the triangular sweep sequencer.
package sweep_pkg;
    localparam int SWEEP_WIDTH   = 8;
    localparam int SWEEP_DWELL_W = 4;
    localparam int SWEEP_REP_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO,
        S_DONE
    } sweep_state_t;
endpackage

// File: rtl/updown_counter8.sv
// Up/down counter with synchronous clear; wraps modulo 2^WIDTH.
// Count updates one cycle after enable; clear overrides enable.
module updown_counter8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             enable,
    input  logic             direction,
    output logic [WIDTH-1:0] count_out
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            count_out <= '0;
        else if (enable)
            count_out <= direction ? count_out + WIDTH'(1) : count_out - WIDTH'(1);
    end
endmodule

// File: rtl/sweep_controller.sv
// Runs triangular lo->hi->lo sweeps on an owned up/down counter with dwell and repeats.
// Counter enable is combinational from state/value; abort freezes the count in the same cycle.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int WIDTH   = SWEEP_WIDTH,
    parameter int DWELL_W = SWEEP_DWELL_W,
    parameter int REP_W   = SWEEP_REP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REP_W-1:0]   reps,
    output logic [WIDTH-1:0]   value,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               err
);
    sweep_state_t       state;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [DWELL_W-1:0] dwell_q, dcnt;
    logic [REP_W-1:0]   reps_q, rem;
    logic               clr, at_lo, at_hi, last_sweep;

    assign at_lo      = (value == lo_q);
    assign at_hi      = (value == hi_q);
    assign last_sweep = (reps_q != '0) && (rem == REP_W'(1));

    always_comb begin
        clr     = (state == S_IDLE) && start && (lo < hi);
        cnt_en  = 1'b0;
        cnt_dir = 1'b0;
        case (state)
            S_SEEK: begin cnt_en = !at_lo; cnt_dir = 1'b1; end
            S_UP:   begin cnt_en = !at_hi; cnt_dir = 1'b1; end
            S_DOWN: begin cnt_en = !at_lo; cnt_dir = 1'b0; end
            default: ;
        endcase
        if (abort)
            cnt_en = 1'b0;
    end

    updown_counter8 #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .enable    (cnt_en),
        .direction (cnt_dir),
        .count_out (value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            reps_q  <= '0;
            dcnt    <= '0;
            rem     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lo_q    <= lo;
                        hi_q    <= hi;
                        dwell_q <= dwell;
                        reps_q  <= reps;
                        rem     <= reps;
                        busy    <= 1'b1;
                        if (lo >= hi) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= S_SEEK;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    aborted <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    if (abort) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        case (state)
                            S_SEEK: if (at_lo) state <= S_UP;
                            S_UP: if (at_hi) begin
                                if (dwell_q == '0) begin
                                    state <= S_DOWN;
                                end else begin
                                    state <= S_DWELL_HI;
                                    dcnt  <= dwell_q - DWELL_W'(1);
                                end
                            end
                            S_DWELL_HI: begin
                                if (dcnt == '0) state <= S_DOWN;
                                else            dcnt  <= dcnt - DWELL_W'(1);
                            end
                            S_DOWN: if (at_lo) begin
                                if (dwell_q != '0) begin
                                    state <= S_DWELL_LO;
                                    dcnt  <= dwell_q - DWELL_W'(1);
                                end else if (last_sweep) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_UP;
                                    if (reps_q != '0) rem <= rem - REP_W'(1);
                                end
                            end
                            S_DWELL_LO: begin
                                if (dcnt != '0) begin
                                    dcnt <= dcnt - DWELL_W'(1);
                                end else if (last_sweep) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= S_UP;
                                    if (reps_q != '0) rem <= rem - REP_W'(1);
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_controller.sv
// Table-driven and randomized checks of sweep_controller against a value-sequence model.
module tb_sweep_controller;
    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] lo, hi, value;
    logic [3:0] dwell, reps;
    logic       cnt_en, cnt_dir, busy, done, aborted, err;

    always #5 clk = ~clk;

    sweep_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .dwell(dwell), .reps(reps),
        .value(value), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;
    int last_val = 0;
    int exp_q[$];

    typedef struct {
        int l, h, d, r;
        int cycles;      // edges from start edge to done; -1 = take from model
        int abort_at;    // interval index at which abort is raised; -1 = none
        int restart_at;  // interval index of an ignored start pulse; -1 = none
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Expected counter value for every cycle of a run, straight from the sweep rules.
    task automatic build(input int l, input int h, input int d, input int n);
        exp_q.delete();
        for (int v = 0; v <= l; v++) exp_q.push_back(v);
        for (int s = 0; s < n; s++) begin
            for (int v = l; v <= h; v++) exp_q.push_back(v);
            for (int i = 0; i < d; i++) exp_q.push_back(h);
            for (int v = h; v >= l; v--) exp_q.push_back(v);
            for (int i = 0; i < d; i++) exp_q.push_back(l);
        end
    endtask

    task automatic run(input vec_t t, input string tag);
        int tdone, stop, exp_en, fin;
        @(negedge clk);
        lo = 8'(t.l); hi = 8'(t.h); dwell = 4'(t.d); reps = 4'(t.r); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (t.l >= t.h) begin
            chk({tag, " err done"}, done, 1);
            chk({tag, " err flag"}, err, 1);
            chk({tag, " err aborted"}, aborted, 0);
            chk({tag, " err busy"}, busy, 1);
            chk({tag, " err value kept"}, value, last_val);
            @(negedge clk);
            chk({tag, " err busy drop"}, busy, 0);
            chk({tag, " err done pulse"}, done, 0);
            return;
        end
        build(t.l, t.h, t.d, (t.r == 0) ? 3 : t.r);
        tdone = (t.cycles >= 0) ? t.cycles : exp_q.size();
        stop  = (t.abort_at >= 0) ? t.abort_at + 1 : tdone;
        for (int k = 0; k < stop; k++) begin
            chk({tag, " value"}, value, exp_q[k]);
            chk({tag, " done early"}, done, 0);
            chk({tag, " busy"}, busy, 1);
            if (k == t.abort_at) begin
                abort = 1'b1;
                #1;
                chk({tag, " en at abort"}, cnt_en, 0);
            end else begin
                exp_en = (k + 1 < exp_q.size() && exp_q[k+1] != exp_q[k]) ? 1 : 0;
                chk({tag, " cnt_en"}, cnt_en, exp_en);
                if (exp_en == 1) chk({tag, " cnt_dir"}, cnt_dir, (exp_q[k+1] > exp_q[k]) ? 1 : 0);
            end
            if (k == t.restart_at) begin
                start = 1'b1; lo = 8'd0; hi = 8'd9;
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
        end
        fin = exp_q[stop-1];
        chk({tag, " done"}, done, 1);
        chk({tag, " busy at done"}, busy, 1);
        chk({tag, " aborted"}, aborted, (t.abort_at >= 0) ? 1 : 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " final value"}, value, fin);
        last_val = fin;
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " busy drop"}, busy, 0);
        chk({tag, " value held"}, value, fin);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{2, 5,   0, 1, 11,  -1, -1};  // basic sweep
        tbl[1] = '{0, 3,   2, 2, 25,  -1, -1};  // dwell and repeats
        tbl[2] = '{7, 7,   0, 1, 0,   -1, -1};  // equal bounds rejected
        tbl[3] = '{0, 200, 0, 0, -1,  51, -1};  // abort mid-UP at value 50
        tbl[4] = '{2, 5,   0, 1, 11,  -1, 3};   // start while busy ignored
        tbl[5] = '{0, 255, 0, 1, 513, -1, -1};  // full range, no wrap
        tbl[6] = '{1, 2,   1, 3, 20,  -1, -1};
        tbl[7] = '{3, 4,   0, 2, 12,  11, -1};  // abort on the natural finish cycle
        tbl[8] = '{9, 3,   0, 1, 0,   -1, -1};  // lo > hi rejected

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; dwell = '0; reps = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset value", value, 0);
        chk("reset cnt_en", cnt_en, 0);
        chk("reset cnt_dir", cnt_dir, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset aborted", aborted, 0);
        chk("reset err", err, 0);

        for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Reset while counting down: no done pulse, counter cleared.
        @(negedge clk);
        lo = 8'd1; hi = 8'd6; dwell = 4'd0; reps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset value", value, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun rst value", value, 0);
        chk("midrun rst busy", busy, 0);
        chk("midrun rst done", done, 0);
        chk("midrun rst cnt_en", cnt_en, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no done after rst", done, 0);
        end
        last_val = 0;

        for (int i = 0; i < 20; i++) begin
            rv.l = int'($urandom_range(0, 20));
            rv.h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rv.l)) : rv.l + int'($urandom_range(1, 15));
            rv.d = int'($urandom_range(0, 3));
            rv.r = int'($urandom_range(1, 3));
            rv.cycles = -1;
            rv.restart_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            build(rv.l, rv.h, rv.d, rv.r);
            rv.abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            run(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
